// File: rtl/core_mrnw1p_wrsched_if.sv
// Write-side bus of the bank-conflict scheduler: per-port
// valid/ready requests in, per-lane core writes out.
interface core_mrnw1p_wrsched_if #(
   parameter int WIDTH   = 32,
   parameter int BITADDR = 13,
   parameter int NUMWRPT = 3
) ();
   logic [NUMWRPT-1:0]         wr_vld;
   logic [NUMWRPT-1:0]         wr_rdy;
   logic [NUMWRPT*BITADDR-1:0] wr_addr;
   logic [NUMWRPT*WIDTH-1:0]   wr_din;
   logic                       core_rdy;
   logic [NUMWRPT-1:0]         vwrite;
   logic [NUMWRPT*BITADDR-1:0] vwraddr;
   logic [NUMWRPT*WIDTH-1:0]   vdin;

   modport master (
      output wr_vld, wr_addr, wr_din, core_rdy,
      input  wr_rdy, vwrite, vwraddr, vdin
   );

   modport slave (
      input  wr_vld, wr_addr, wr_din, core_rdy,
      output wr_rdy, vwrite, vwraddr, vdin
   );
endinterface

// File: rtl/core_mrnw1p_wrsched.sv
// Write-port bank-conflict scheduler: per-port FIFOs, one issue per bank.
// Optional conflict counter: define CORE_MRNW1P_WRSCHED_CNT_EN.
module core_mrnw1p_wrsched #(
   parameter int WIDTH   = 32,
   parameter int BITADDR = 13,
   parameter int NUMADDR = 8192,
   parameter int NUMWRPT = 3,
   parameter int NUMVBNK = 8,
   parameter int BITVBNK = 3,
   parameter int NUMVROW = 1024,
   parameter int BITVROW = 10,
   parameter int FIFODPT = 4,
   parameter int BITFIFO = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   core_mrnw1p_wrsched_if.slave    bus,
   output logic                    idle,
   output logic [15:0]             cflt_cnt
);

   localparam int ENTW = BITADDR + WIDTH;
   localparam int OCCW = BITFIFO + 1;
   localparam int RRW  = (NUMWRPT > 1) ? $clog2(NUMWRPT) : 1;

   if ((NUMVBNK * NUMVROW < NUMADDR) || ((1 << BITVROW) < NUMVROW) ||
       ((1 << BITVBNK) < NUMVBNK) || ((1 << BITFIFO) != FIFODPT) ||
       (FIFODPT < 2)) begin : g_bad_cfg
      $error("core_mrnw1p_wrsched: inconsistent geometry parameters");
   end

   logic [ENTW-1:0]    mem_q  [NUMWRPT][FIFODPT];
   logic [BITFIFO-1:0] wptr_q [NUMWRPT];
   logic [BITFIFO-1:0] wptr_d [NUMWRPT];
   logic [BITFIFO-1:0] rptr_q [NUMWRPT];
   logic [BITFIFO-1:0] rptr_d [NUMWRPT];
   logic [OCCW-1:0]    occ_q  [NUMWRPT];
   logic [OCCW-1:0]    occ_d  [NUMWRPT];
   logic [RRW-1:0]     rr_q, rr_d;

   logic [NUMWRPT-1:0]         vwrite_q, vwrite_d;
   logic [NUMWRPT*BITADDR-1:0] vwraddr_q, vwraddr_d;
   logic [NUMWRPT*WIDTH-1:0]   vdin_q, vdin_d;
   logic                       idle_q, idle_d;

   logic [NUMWRPT-1:0] rdy;
   logic [NUMWRPT-1:0] push;
   logic [NUMWRPT-1:0] grant;
   logic               denied;
   logic [BITADDR-1:0] head_addr [NUMWRPT];
   logic [WIDTH-1:0]   head_data [NUMWRPT];
   logic [BITVBNK-1:0] head_bnk  [NUMWRPT];

   // Accept side and head decode; a full FIFO refuses even while popping.
   always_comb begin
      rdy  = '0;
      push = '0;
      for (int p = 0; p < NUMWRPT; p++) begin
         rdy[p]  = rst & bus.core_rdy & (occ_q[p] != OCCW'(FIFODPT));
         push[p] = bus.wr_vld[p] & rdy[p];
         {head_addr[p], head_data[p]} = mem_q[p][rptr_q[p]];
         head_bnk[p] = BITVBNK'(head_addr[p] % BITADDR'(NUMVBNK));
      end
   end

   assign bus.wr_rdy = rdy;

   // Round-robin scan from rr; first port to claim a bank wins it.
   always_comb begin
      logic [NUMVBNK-1:0] claimed;
      int                 p;
      claimed = '0;
      grant   = '0;
      denied  = 1'b0;
      p       = 0;
      if (bus.core_rdy) begin
         for (int k = 0; k < NUMWRPT; k++) begin
            p = (int'(rr_q) + k) % NUMWRPT;
            if (occ_q[p] != '0) begin
               if (claimed[head_bnk[p]]) begin
                  denied = 1'b1;
               end else begin
                  grant[p]               = 1'b1;
                  claimed[head_bnk[p]]   = 1'b1;
               end
            end
         end
      end
   end

   // Next state: FIFO pointers/occupancy, issued lanes, priority, idle.
   always_comb begin
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      occ_d     = occ_q;
      vwrite_d  = grant;
      vwraddr_d = '0;
      vdin_d    = '0;
      rr_d      = rr_q;
      idle_d    = (grant == '0);
      for (int p = 0; p < NUMWRPT; p++) begin
         if (push[p]) begin
            wptr_d[p] = wptr_q[p] + BITFIFO'(1);
         end
         if (grant[p]) begin
            rptr_d[p] = rptr_q[p] + BITFIFO'(1);
            vwraddr_d[p*BITADDR +: BITADDR] = head_addr[p];
            vdin_d[p*WIDTH +: WIDTH]        = head_data[p];
         end
         occ_d[p] = occ_q[p] + OCCW'(push[p]) - OCCW'(grant[p]);
         if (occ_d[p] != '0) begin
            idle_d = 1'b0;
         end
      end
      if (denied) begin
         rr_d = (rr_q == RRW'(NUMWRPT - 1)) ? '0 : rr_q + RRW'(1);
      end
   end

   // Control state; reset discards everything queued.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int p = 0; p < NUMWRPT; p++) begin
            wptr_q[p] <= '0;
            rptr_q[p] <= '0;
            occ_q[p]  <= '0;
         end
         rr_q      <= '0;
         vwrite_q  <= '0;
         vwraddr_q <= '0;
         vdin_q    <= '0;
         idle_q    <= 1'b1;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         occ_q     <= occ_d;
         rr_q      <= rr_d;
         vwrite_q  <= vwrite_d;
         vwraddr_q <= vwraddr_d;
         vdin_q    <= vdin_d;
         idle_q    <= idle_d;
      end
   end

   // FIFO storage; contents are don't-care until pointed at.
   always_ff @(posedge clk) begin
      for (int p = 0; p < NUMWRPT; p++) begin
         if (push[p]) begin
            mem_q[p][wptr_q[p]] <= {bus.wr_addr[p*BITADDR +: BITADDR],
                                    bus.wr_din[p*WIDTH +: WIDTH]};
         end
      end
   end

   assign bus.vwrite  = vwrite_q;
   assign bus.vwraddr = vwraddr_q;
   assign bus.vdin    = vdin_q;
   assign idle        = idle_q;

`ifdef CORE_MRNW1P_WRSCHED_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   // Saturating count of cycles with at least one denied head.
   always_comb begin
      cnt_d = cnt_q;
      if (denied && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cflt_cnt = cnt_q;
`else
   assign cflt_cnt = '0;
`endif

endmodule
